huff_bit_packer: RTL
====================

HUFF_BIT_PACKER -- requirements
Module: huff_bit_packer

Interface
REQ-001 Parameters: none; the accumulator is fixed at 32 bits and the input code field at 16 bits.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_data  input  16  packed code: Huffman bits already reversed plus extra bits; bit0 is transmitted first.
REQ-005 in_nbits  input  5  number of valid low bits of in_data, 0..16.
REQ-006 in_valid  input  1  in_data/in_nbits valid.
REQ-007 in_ready  output  1  packer can accept a code this cycle.
REQ-008 flush  input  1  request to pad to a byte boundary and drain.
REQ-009 out_byte  output  8  next output byte, LSB-first bit order.
REQ-010 out_valid  output  1  out_byte valid.
REQ-011 out_ready  input  1  consumer takes out_byte.
REQ-012 flush_done  output  1  one-cycle pulse when a flush completes.
REQ-013 bit_count  output  32  total accepted bits (see Configuration).

Function
REQ-014 State: acc[31:0] and fill[5:0] (0..32); FSM states RUN, FLUSH, DONE.
REQ-015 in_ready = (state==RUN) && (fill<=16), decoded from registers only, with no combinational path from inputs.
REQ-016 out_valid = (fill>=8); out_byte = acc[7:0].
REQ-017 Output transfer (out_valid && out_ready): acc shifts right 8 and fill decreases by 8.
REQ-018 Input transfer (in_valid && in_ready): masked data (bits >= in_nbits forced 0) is ORed into acc at bit position fill', where fill' is fill after any same-cycle output transfer; fill = fill' + in_nbits.
REQ-019 in_nbits > 16 is clamped to 16; in_nbits = 0 is accepted with no change to acc or fill.
REQ-020 Latency: a byte completed by an accept is presented on out_byte the following cycle.
REQ-021 out_byte and out_valid hold stable while out_valid && !out_ready.
REQ-022 RUN -> FLUSH when flush=1 in RUN; any same-cycle input transfer is included before the flush.
REQ-023 FLUSH: in_ready=0; drain full bytes. When 1<=fill<=7, out_valid=1 with upper bits zero-padded; its transfer sets fill=0 and acc=0. When fill=0, go to DONE.
REQ-024 DONE: flush_done=1 for exactly one cycle, then RUN; flush asserted while in FLUSH or DONE is ignored.
REQ-025 A flush with fill=0 reaches DONE on the next cycle and pulses flush_done; no byte is emitted.
REQ-026 Bits beyond fill in acc are always 0.

Reset
REQ-027 While rst_n=0: acc=0, fill=0, state=RUN, out_valid=0, flush_done=0, bit_count=0; in_ready=1 once reset is released.
REQ-028 Reset asserted mid-operation discards all buffered bits and any pending flush immediately.

Configuration
REQ-029 Macro PACKER_BITCNT_EN defined: bit_count adds the clamped in_nbits on every input transfer, wraps modulo 2^32, and is not cleared by flush.
REQ-030 Macro PACKER_BITCNT_EN undefined: bit_count is tied to 0 and no counter logic is synthesized; all other behaviour is identical.

Verification
REQ-031 Send {0x40,7} then {0x01,7}, then pulse flush -> bytes 0xC0, 0x00 (padded 6 bits); flush_done pulses once.
REQ-032 Send {0xA5C3,16} with out_ready=1 -> bytes 0xC3 then 0xA5; fill returns to 0.
REQ-033 Hold out_ready=0 and send {0x1234,16} and {0x5678,16} -> both accepted (fill=32); a third code stalls with in_ready=0. Release -> bytes 0x34, 0x12, 0x78, 0x56 in order.
REQ-034 Send {0xFFFF,3}, then {0x0000,0}, then flush -> single byte 0x07; with PACKER_BITCNT_EN, bit_count=3.
REQ-035 Send {0xFF,12}, assert rst_n=0 for 1 cycle -> out_valid=0 and fill=0; after reset, {0x5A,8} -> byte 0x5A.
REQ-036 flush with an empty packer -> no byte; flush_done 1 cycle later; in_ready=1 after DONE.

Source files
------------

// File: rtl/huff_bit_packer.sv
// Huffman bit packer: accumulates LSB-first variable-length codes (0..16 bits) into bytes.
// Latency: a byte completed by an accept is presented on out_byte the following cycle.
// Backpressure: in_ready drops when more than 16 bits are buffered; out_byte holds while out_ready=0.
// Optional feature: define PACKER_BITCNT_EN to enable the running bit_count of accepted bits.
module huff_bit_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in_data,
    input  logic [4:0]  in_nbits,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        flush_done,
    output logic [31:0] bit_count
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [31:0] acc;
    logic [31:0] acc_nxt;
    logic [31:0] acc_post;
    logic [5:0]  fill;
    logic [5:0]  fill_nxt;
    logic [5:0]  fill_post;
    logic [4:0]  nbits_clamp;
    logic [31:0] code_mask;
    logic [31:0] code_ext;
    logic        out_xfer;
    logic        in_xfer;

    // Handshake outputs depend on registered state only, so no input-to-output paths exist.
    assign in_ready   = (state == ST_RUN) && (fill <= 6'd16);
    assign out_valid  = (fill >= 6'd8) || ((state == ST_FLUSH) && (fill != 6'd0));
    assign out_byte   = acc[7:0];
    assign flush_done = (state == ST_DONE);
    assign out_xfer   = out_valid && out_ready;
    assign in_xfer    = in_valid && in_ready;

    // Clamp the code length and mask away bits above it so acc stays clean beyond fill.
    always_comb begin
        nbits_clamp = (in_nbits > 5'd16) ? 5'd16 : in_nbits;
        code_mask   = (32'd1 << nbits_clamp) - 32'd1;
        code_ext    = {16'd0, in_data} & code_mask;
    end

    // Next accumulator: retire the outgoing byte first, then append the new code above what remains.
    always_comb begin
        acc_post  = acc;
        fill_post = fill;
        if (out_xfer) begin
            if (fill >= 6'd8) begin
                acc_post  = acc >> 8;
                fill_post = fill - 6'd8;
            end else begin
                // Padded tail byte during flush: everything left has just been sent.
                acc_post  = 32'd0;
                fill_post = 6'd0;
            end
        end
        acc_nxt  = acc_post;
        fill_nxt = fill_post;
        if (in_xfer) begin
            acc_nxt  = acc_post | (code_ext << fill_post);
            fill_nxt = fill_post + {1'b0, nbits_clamp};
        end
    end

    // Flush sequencing: leave for DONE as soon as the buffer will be empty after this cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (flush) begin
                    state_nxt = (fill_nxt == 6'd0) ? ST_DONE : ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (fill_nxt == 6'd0) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE:  state_nxt = ST_RUN;
            default:  state_nxt = ST_RUN;
        endcase
    end

    // Core state registers; reset discards buffered bits and any pending flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
            acc   <= 32'd0;
            fill  <= 6'd0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            fill  <= fill_nxt;
        end
    end

`ifdef PACKER_BITCNT_EN
    logic [31:0] bit_cnt;

    // Running total of accepted code bits, wrapping naturally; flush does not clear it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= 32'd0;
        end else if (in_xfer) begin
            bit_cnt <= bit_cnt + {27'd0, nbits_clamp};
        end
    end

    assign bit_count = bit_cnt;
`else
    assign bit_count = 32'd0;
`endif

endmodule
